// File: rtl/crypt_pkg.sv
// Shared definitions for the cipher-core arbiter: sequencer states, default
// data width and requester IDs.
package crypt_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic REQ_ENC = 1'b0;
   localparam logic REQ_DEC = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational winner, registered last grant.
module rr_arbiter2
   import crypt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic last_grant;

   // On contention the requester that was not served last time wins.
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == REQ_DEC) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      gnt_id = gnt[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= REQ_DEC;
      end else if (grant_en && (gnt != 2'b00)) begin
         last_grant <= gnt_id;
      end
   end

endmodule

// File: rtl/crypt_core_arbiter.sv
// Round-robin arbiter and sequencer for the shared cipher core: grants one
// requester, launches the core, waits with timeout and returns a tagged response.
module crypt_core_arbiter
   import crypt_pkg::*;
#(
   parameter int unsigned DATA_W  = crypt_pkg::DATA_W,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              core_sel,
   output logic [DATA_W-1:0] core_data,
   output logic              core_start,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_result,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              rsp_err,
   input  logic              rsp_ready
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             idle_ok;
   logic             accept;
   logic             timed_out;

   // Readies only in IDLE and never while reset is held.
   assign idle_ok    = (state == IDLE) && !rst;
   assign req0_ready = idle_ok && gnt[0];
   assign req1_ready = idle_ok && gnt[1];
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign timed_out  = (cnt == CNT_LAST);

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      ({req1_valid, req0_valid}),
      .grant_en (accept),
      .gnt      (gnt),
      .gnt_id   (gnt_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (core_done || timed_out) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and response registers; core_done only matters in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_sel   <= 1'b0;
         core_data  <= '0;
         core_start <= 1'b0;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         core_start <= accept;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  core_sel  <= gnt_id;
                  core_data <= gnt_id ? req1_data : req0_data;
                  rsp_id    <= gnt_id;
               end
            end
            ISSUE: begin
               cnt <= '0;
            end
            WAIT: begin
               if (core_done) begin
                  rsp_data  <= core_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
               end else if (timed_out) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crypt_core_arbiter.sv
// Directed bench for crypt_core_arbiter with a behavioural cipher core
// (result = operand ^ 0x99) and a response scoreboard.
module tb_crypt_core_arbiter;
   import crypt_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = '0, req1_data = '0;
   logic       req0_ready, req1_ready;
   logic       core_sel, core_start;
   logic [7:0] core_data;
   wire        core_done;
   wire  [7:0] core_result;
   logic       rsp_valid, rsp_id, rsp_err;
   logic [7:0] rsp_data;
   logic       rsp_ready = 1'b1;

   typedef struct packed {
      logic       id;
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   int         core_lat = 2;
   bit         core_en  = 1'b1;
   int         mcnt     = 0;
   logic       model_done = 1'b0;
   logic [7:0] model_res = '0, mop = '0;
   logic       tb_done = 1'b0;
   logic [7:0] tb_res = '0;

   assign core_done   = model_done | tb_done;
   assign core_result = model_done ? model_res : tb_res;

   crypt_core_arbiter #(.DATA_W(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .core_sel(core_sel), .core_data(core_data), .core_start(core_start),
      .core_done(core_done), .core_result(core_result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < 64) begin
         tick();
         cyc++;
      end
      chk("rsp_seen", 32'(rsp_valid), 32'd1);
   endtask

   // Behavioural core: done pulse core_lat cycles after the start pulse.
   always @(negedge clk) begin
      model_done = 1'b0;
      if (rst) begin
         mcnt = 0;
      end else if (core_start && core_en) begin
         mcnt = core_lat;
         mop  = core_data;
      end else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            model_done = 1'b1;
            model_res  = mop ^ 8'h99;
         end
      end
   end

   // Response scoreboard and ready exclusivity.
   always @(negedge clk) begin
      if (!rst) begin
         chk("both_ready", 32'(req0_ready & req1_ready), 32'd0);
         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      int cyc;
      int cnt_wait;
      logic exp_id;
      logic [7:0] exp_op;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_sel", 32'(core_sel), 32'd0);
      chk("rst_core_start", 32'(core_start), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      rst = 1'b0;
      tick();

      // Single request from the encrypt path.
      core_lat = 2;
      req0_valid = 1'b1;
      req0_data  = 8'h3C;
      #1;
      chk("single_ready0", 32'(req0_ready), 32'd1);
      chk("single_ready1", 32'(req1_ready), 32'd0);
      sb.push_back('{id: REQ_ENC, err: 1'b0, data: 8'hA5});
      tick();
      req0_valid = 1'b0;
      chk("single_start", 32'(core_start), 32'd1);
      chk("single_sel", 32'(core_sel), 32'd0);
      chk("single_core_data", 32'(core_data), 32'h3C);
      wait_rsp(cyc);
      chk("single_latency", 32'(cyc), 32'd3);
      tick();

      // Timeout: core never answers.
      core_en = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 8'h5A;
      #1;
      chk("to_ready0", 32'(req0_ready), 32'd1);
      sb.push_back('{id: REQ_ENC, err: 1'b1, data: 8'h00});
      tick();
      req0_valid = 1'b0;
      wait_rsp(cyc);
      chk("to_latency", 32'(cyc), 32'd16);
      chk("to_err", 32'(rsp_err), 32'd1);
      chk("to_data", 32'(rsp_data), 32'd0);
      tick();
      core_en = 1'b1;

      // Late / spurious done pulses in IDLE are ignored.
      tb_done = 1'b1;
      tb_res  = 8'hFF;
      tick();
      tb_done = 1'b0;
      repeat (3) begin
         chk("spurious_no_rsp", 32'(rsp_valid), 32'd0);
         chk("spurious_no_start", 32'(core_start), 32'd0);
         tick();
      end
      req1_valid = 1'b1;
      req1_data  = 8'h42;
      #1;
      chk("spurious_idle_ready1", 32'(req1_ready), 32'd1);
      sb.push_back('{id: REQ_DEC, err: 1'b0, data: 8'hDB});
      tick();
      req1_valid = 1'b0;
      chk("dec_sel", 32'(core_sel), 32'd1);
      chk("dec_start", 32'(core_start), 32'd1);
      wait_rsp(cyc);
      tick();

      // Backpressure: consumer stalls for 10 cycles.
      rsp_ready = 1'b0;
      core_lat  = 1;
      req0_valid = 1'b1;
      req0_data  = 8'h77;
      #1;
      sb.push_back('{id: REQ_ENC, err: 1'b0, data: 8'hEE});
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_data  = 8'h55;
      wait_rsp(cyc);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data", 32'(rsp_data), 32'hEE);
         chk("bp_id", 32'(rsp_id), 32'd0);
         chk("bp_err", 32'(rsp_err), 32'd0);
         chk("bp_ready1", 32'(req1_ready), 32'd0);
         chk("bp_start", 32'(core_start), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);
      chk("bp_release_ready1", 32'(req1_ready), 32'd1);
      req1_valid = 1'b0;
      tick();

      // Reset two cycles after core_start.
      core_lat = 8;
      req1_valid = 1'b1;
      req1_data  = 8'h81;
      tick();
      req1_valid = 1'b0;
      chk("rstw_start", 32'(core_start), 32'd1);
      tick();
      tick();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("rstw_core_sel", 32'(core_sel), 32'd0);
      chk("rstw_core_data", 32'(core_data), 32'd0);
      chk("rstw_core_start", 32'(core_start), 32'd0);
      chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstw_rsp_id", 32'(rsp_id), 32'd0);
      chk("rstw_ready0", 32'(req0_ready), 32'd0);
      chk("rstw_ready1", 32'(req1_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Contention: grants alternate starting with req0.
      core_lat = 1;
      for (int i = 0; i < 4; i++) begin
         req0_data = 8'(8'h10 + i);
         req1_data = 8'(8'hC0 + i);
         #1;
         cnt_wait = 0;
         while (!(req0_ready || req1_ready) && cnt_wait < 16) begin
            tick();
            cnt_wait++;
         end
         exp_id = 1'(i % 2);
         exp_op = exp_id ? 8'(8'hC0 + i) : 8'(8'h10 + i);
         chk("cont_ready1", 32'(req1_ready), 32'(exp_id));
         chk("cont_ready0", 32'(req0_ready), 32'(!exp_id));
         sb.push_back('{id: exp_id, err: 1'b0, data: exp_op ^ 8'h99});
         tick();
         chk("cont_sel", 32'(core_sel), 32'(exp_id));
         chk("cont_start", 32'(core_start), 32'd1);
         chk("cont_core_data", 32'(core_data), 32'(exp_op));
         wait_rsp(cyc);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
